// File: rtl/hazard_stall_unit_pkg.sv
// hazard_pkg: shared types and helpers for the decode/issue hazard stall unit.
//   REG_IDX_W / CSR_ADDR_W : operand index widths seen at decode
//   stall_cause_e          : why decode is being held (debug visibility)
//   is_x0                  : x0 is hardwired, so it never carries a hazard
package hazard_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int CSR_ADDR_W = 12;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_RS1    = 3'd1,
    CAUSE_RS2    = 3'd2,
    CAUSE_CSR_RD = 3'd3,
    CAUSE_CSR_WR = 3'd4,
    CAUSE_SAT    = 3'd5
  } stall_cause_e;

  function automatic logic is_x0(input logic [REG_IDX_W-1:0] r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_pend_counter.sv
// pend_counter: outstanding-write counter for one GPR.
//   clk, rst_n : clock, async active-low reset
//   inc        : one new long-latency write issued to this register
//   dec        : releases this cycle (wb and/or kill, 0..2)
//   cnt        : registered count of outstanding writes
//   pend       : count still non-zero after this cycle's releases (WB bypass)
//   sat        : count is at max and nothing releases this cycle
//   underflow  : more releases than outstanding writes (pulse)
module pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             pend,
  output logic             sat,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   up;
  logic [CNT_W:0]   dec_w;
  logic [CNT_W:0]   nxt;

  // One guard bit so cnt+inc and the release compare cannot wrap.
  assign up        = {1'b0, cnt_q} + (CNT_W+1)'(inc);
  assign dec_w     = (CNT_W+1)'(dec);
  assign underflow = (dec_w > up);
  assign nxt       = underflow ? '0 : (up - dec_w);

  assign cnt  = cnt_q;
  assign pend = ({1'b0, cnt_q} > dec_w);
  // A release this cycle frees a slot, so a new write can issue alongside it.
  assign sat  = (cnt_q == '1) && (dec == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= nxt[CNT_W-1:0];
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: holds decode while a source operand (GPR or CSR) still
// waits on a long-latency producer the forwarding path cannot supply yet.
//   clk, rst_n        : clock, async active-low reset
//   dec_*             : instruction at decode (sources, dest, CSR use)
//   wb_valid/wb_rd    : long-latency GPR writeback this cycle
//   csr_wb_valid      : outstanding CSR write retires this cycle
//   kill_*            : squashed op releases its GPR / CSR entry
//   stall_o / issue_o : hold decode / instruction accepted
//   busy_o            : anything outstanding
//   stall_cnt_o       : free-running stall cycle counter (wraps)
//   timeout_o         : sticky, STALL_TIMEOUT consecutive stall cycles seen
//   err_underflow_o   : sticky, release with nothing outstanding
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int CNT_W         = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid,
  input  logic [REG_IDX_W-1:0]  dec_rs1,
  input  logic [REG_IDX_W-1:0]  dec_rs2,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  logic [CSR_ADDR_W-1:0] dec_csr,
  input  logic                  dec_uses_csr,
  input  logic [REG_IDX_W-1:0]  dec_rd,
  input  logic                  dec_long,
  input  logic                  dec_csr_we,
  input  logic                  wb_valid,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  input  logic                  csr_wb_valid,
  input  logic                  kill_valid,
  input  logic [REG_IDX_W-1:0]  kill_rd,
  input  logic                  kill_csr,
  output logic                  stall_o,
  output logic                  issue_o,
  output logic                  busy_o,
  output logic [31:0]           stall_cnt_o,
  output logic                  timeout_o,
  output logic                  err_underflow_o
);

  localparam int TW = $clog2(STALL_TIMEOUT + 1);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            pend;
  logic [NUM_REGS-1:0]            sat;
  logic [NUM_REGS-1:0]            udf;

  logic                  csr_pend_q;
  logic [CSR_ADDR_W-1:0] csr_addr_q;
  logic                  csr_clr;
  logic [TW-1:0]         consec_q;
  stall_cause_e          stall_cause;

  // x0 is hardwired: no counter, never pending.
  assign cnt[0]  = '0;
  assign pend[0] = 1'b0;
  assign sat[0]  = 1'b0;
  assign udf[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [1:0] rel;
    logic       inc;
    assign rel = {1'b0, wb_valid   && (wb_rd   == REG_IDX_W'(r))}
               + {1'b0, kill_valid && (kill_rd == REG_IDX_W'(r))};
    assign inc = issue_o && dec_long && (dec_rd == REG_IDX_W'(r));

    pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc),
      .dec       (rel),
      .cnt       (cnt[r]),
      .pend      (pend[r]),
      .sat       (sat[r]),
      .underflow (udf[r])
    );
  end

  assign csr_clr = csr_wb_valid || kill_csr;

  // Priority only matters for the debug cause; any hit stalls.
  always_comb begin
    stall_cause = CAUSE_NONE;
    if (dec_valid) begin
      if (dec_uses_rs1 && pend[dec_rs1])
        stall_cause = CAUSE_RS1;
      else if (dec_uses_rs2 && pend[dec_rs2])
        stall_cause = CAUSE_RS2;
      else if (dec_uses_csr && csr_pend_q && (csr_addr_q == dec_csr) && !csr_clr)
        stall_cause = CAUSE_CSR_RD;
      else if (dec_csr_we && csr_pend_q && !csr_clr)
        stall_cause = CAUSE_CSR_WR;
      else if (dec_long && !is_x0(dec_rd) && sat[dec_rd])
        stall_cause = CAUSE_SAT;
    end
  end

  assign stall_o = (stall_cause != CAUSE_NONE);
  assign issue_o = dec_valid && !stall_o;
  assign busy_o  = csr_pend_q || (|cnt);

  // Single CSR entry; a new write issuing wins over a same-cycle retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_pend_q <= 1'b0;
      csr_addr_q <= '0;
    end else if (issue_o && dec_csr_we) begin
      csr_pend_q <= 1'b1;
      csr_addr_q <= dec_csr;
    end else if (csr_clr) begin
      csr_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_underflow_o <= 1'b0;
    else if ((|udf) || (csr_clr && !csr_pend_q)) err_underflow_o <= 1'b1;
  end

  // consec_q saturates at STALL_TIMEOUT; timeout_o sets on the edge that
  // completes the STALL_TIMEOUT-th consecutive stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      consec_q    <= '0;
      timeout_o   <= 1'b0;
    end else if (stall_o) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
      if (consec_q != TW'(STALL_TIMEOUT)) consec_q <= consec_q + TW'(1);
      if (consec_q >= TW'(STALL_TIMEOUT - 1)) timeout_o <= 1'b1;
    end else begin
      consec_q <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import hazard_pkg::*;

  localparam int NR   = 32;
  localparam int CW   = 2;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_uses_rs1, dec_uses_rs2, dec_uses_csr, dec_long, dec_csr_we;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd, kill_rd;
  logic [11:0] dec_csr;
  logic        wb_valid, csr_wb_valid, kill_valid, kill_csr;
  logic        stall_o, issue_o, busy_o, timeout_o, err_underflow_o;
  logic [31:0] stall_cnt_o;

  hazard_stall_unit #(.NUM_REGS(NR), .CNT_W(CW), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_csr(dec_csr), .dec_uses_csr(dec_uses_csr), .dec_rd(dec_rd),
    .dec_long(dec_long), .dec_csr_we(dec_csr_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .csr_wb_valid(csr_wb_valid),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_csr(kill_csr),
    .stall_o(stall_o), .issue_o(issue_o), .busy_o(busy_o),
    .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o),
    .err_underflow_o(err_underflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers per register.
  int          mcnt [NR];
  bit          mcsr_pend;
  logic [11:0] mcsr_addr;
  logic [31:0] mstall;
  int          mconsec;
  bit          mto, mudf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    dec_valid = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_uses_csr = 0;
    dec_long = 0; dec_csr_we = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_csr = 0; wb_valid = 0; wb_rd = 0; csr_wb_valid = 0;
    kill_valid = 0; kill_rd = 0; kill_csr = 0;
  endtask

  task automatic m_reset();
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    mcsr_pend = 0; mcsr_addr = 0; mstall = 0; mconsec = 0; mto = 0; mudf = 0;
  endtask

  function automatic int rel(input int r);
    if (r == 0) return 0;
    return ((wb_valid && wb_rd == r) ? 1 : 0) + ((kill_valid && kill_rd == r) ? 1 : 0);
  endfunction

  function automatic stall_cause_e m_cause();
    bit clr;
    clr = csr_wb_valid || kill_csr;
    if (!dec_valid) return CAUSE_NONE;
    if (dec_uses_rs1 && dec_rs1 != 0 && mcnt[dec_rs1] - rel(dec_rs1) > 0) return CAUSE_RS1;
    if (dec_uses_rs2 && dec_rs2 != 0 && mcnt[dec_rs2] - rel(dec_rs2) > 0) return CAUSE_RS2;
    if (dec_uses_csr && mcsr_pend && mcsr_addr == dec_csr && !clr) return CAUSE_CSR_RD;
    if (dec_csr_we && mcsr_pend && !clr) return CAUSE_CSR_WR;
    if (dec_long && dec_rd != 0 && mcnt[dec_rd] - rel(dec_rd) >= MAXC) return CAUSE_SAT;
    return CAUSE_NONE;
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance both.
  task automatic cyc(input string tag, input int exp_stall = -1);
    stall_cause_e c;
    bit es, ei, busy, clr, n_pend, n_udf, n_to;
    int ncnt [NR];
    logic [11:0] n_addr;
    int v;
    #1;
    c  = m_cause();
    es = (c != CAUSE_NONE);
    ei = dec_valid && !es;
    busy = mcsr_pend;
    for (int r = 0; r < NR; r++) if (mcnt[r] != 0) busy = 1;
    chk({tag, ".stall"}, 32'(stall_o), 32'(es));
    chk({tag, ".issue"}, 32'(issue_o), 32'(ei));
    chk({tag, ".busy"},  32'(busy_o), 32'(busy));
    chk({tag, ".scnt"},  stall_cnt_o, mstall);
    chk({tag, ".tmo"},   32'(timeout_o), 32'(mto));
    chk({tag, ".udf"},   32'(err_underflow_o), 32'(mudf));
    if (exp_stall >= 0) chk({tag, ".plan"}, 32'(stall_o), 32'(exp_stall));
    n_udf = mudf;
    for (int r = 0; r < NR; r++) begin
      v = mcnt[r];
      if (r != 0) begin
        v = v + ((ei && dec_long && dec_rd == r) ? 1 : 0) - rel(r);
        if (v < 0) begin v = 0; n_udf = 1; end
      end
      ncnt[r] = v;
    end
    clr = csr_wb_valid || kill_csr;
    if (clr && !mcsr_pend) n_udf = 1;
    n_pend = mcsr_pend; n_addr = mcsr_addr;
    if (ei && dec_csr_we) begin n_pend = 1; n_addr = dec_csr; end
    else if (clr) n_pend = 0;
    n_to = mto || (es && mconsec + 1 >= TO);
    @(posedge clk);
    for (int r = 0; r < NR; r++) mcnt[r] = ncnt[r];
    mcsr_pend = n_pend; mcsr_addr = n_addr; mudf = n_udf; mto = n_to;
    mstall  = mstall + (es ? 32'd1 : 32'd0);
    mconsec = es ? mconsec + 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    m_reset();
    #3;
    dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 5;
    #1;
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.issue", 32'(issue_o), 32'd1);
    chk("rst.busy",  32'(busy_o), 32'd0);
    chk("rst.scnt",  stall_cnt_o, 32'd0);
    chk("rst.tmo",   32'(timeout_o), 32'd0);
    chk("rst.udf",   32'(err_underflow_o), 32'd0);
    @(posedge clk); #1;
    clr_in(); rst_n = 1;

    // load rd=5, dependent rs1=5 stalls until the writeback cycle
    dec_valid = 1; dec_long = 1; dec_rd = 5;   cyc("ld5", 0);
    clr_in(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 5;
    cyc("dep5a", 1);
    cyc("dep5b", 1);
    wb_valid = 1; wb_rd = 5;                   cyc("wb5", 0);
    chk("wb5.issued", 32'(issue_o), 32'd1);
    clr_in();                                  cyc("idle5");
    chk("cnt5.zero", 32'(busy_o), 32'd0);

    // x0 never tracked
    dec_valid = 1; dec_long = 1; dec_rd = 0;   cyc("ld0", 0);
    clr_in(); dec_valid = 1; dec_uses_rs2 = 1; dec_rs2 = 0;
    cyc("dep0", 0);
    chk("x0.busy", 32'(busy_o), 32'd0);

    // saturation on rd=7
    clr_in(); dec_valid = 1; dec_long = 1; dec_rd = 7;
    cyc("ld7a", 0); cyc("ld7b", 0); cyc("ld7c", 0);
    cyc("ld7sat", 1);
    wb_valid = 1; wb_rd = 7;                   cyc("ld7wb", 0);
    wb_valid = 0;                              cyc("ld7still3", 1);
    clr_in(); wb_valid = 1; wb_rd = 7;
    cyc("drain7a"); cyc("drain7b"); cyc("drain7c");
    clr_in();                                  cyc("idle7");

    // CSR hazard
    dec_valid = 1; dec_csr_we = 1; dec_csr = 12'h300; cyc("csrw", 0);
    clr_in(); dec_valid = 1; dec_uses_csr = 1; dec_csr = 12'h305; cyc("csr305", 0);
    dec_csr = 12'h300;                         cyc("csr300", 1);
    kill_csr = 1;                              cyc("csrkill", 0);
    chk("csr.noudf", 32'(err_underflow_o), 32'd0);
    clr_in();                                  cyc("idlecsr");

    // underflow is sticky; async reset mid-stall
    wb_valid = 1; wb_rd = 9;                   cyc("udf9");
    chk("udf9.set", 32'(err_underflow_o), 32'd1);
    clr_in(); dec_valid = 1; dec_long = 1; dec_rd = 3; cyc("ld3", 0);
    clr_in(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 3; cyc("dep3", 1);
    chk("udf.sticky", 32'(err_underflow_o), 32'd1);
    #2; rst_n = 0; #1;
    chk("arst.stall", 32'(stall_o), 32'd0);
    chk("arst.udf",   32'(err_underflow_o), 32'd0);
    chk("arst.busy",  32'(busy_o), 32'd0);
    chk("arst.scnt",  stall_cnt_o, 32'd0);
    m_reset();
    @(posedge clk); #1; rst_n = 1; clr_in();

    // watchdog
    dec_valid = 1; dec_long = 1; dec_rd = 4;   cyc("ld4", 0);
    clr_in(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 4;
    for (int i = 0; i < TO; i++) cyc("wdog", 1);
    chk("wdog.tmo",  32'(timeout_o), 32'd1);
    chk("wdog.scnt", stall_cnt_o, 32'd16);
    wb_valid = 1; wb_rd = 4;                   cyc("wb4", 0);
    chk("tmo.sticky", 32'(timeout_o), 32'd1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      clr_in();
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_uses_rs1 = $urandom_range(0, 1) == 1;
      dec_uses_rs2 = $urandom_range(0, 1) == 1;
      dec_rs1      = 5'($urandom_range(0, 7));
      dec_rs2      = 5'($urandom_range(0, 7));
      dec_rd       = 5'($urandom_range(0, 7));
      dec_long     = ($urandom_range(0, 9) < 4);
      dec_uses_csr = ($urandom_range(0, 3) == 0);
      dec_csr_we   = ($urandom_range(0, 6) == 0);
      dec_csr      = 12'h300 + 12'($urandom_range(0, 1));
      wb_valid     = ($urandom_range(0, 9) < 4);
      wb_rd        = 5'($urandom_range(0, 7));
      kill_valid   = ($urandom_range(0, 9) == 0);
      kill_rd      = 5'($urandom_range(0, 7));
      csr_wb_valid = ($urandom_range(0, 6) == 0);
      kill_csr     = ($urandom_range(0, 19) == 0);
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side counterpart to the EX-stage forwarding mux: tracks in-flight long-latency results (loads, CSR reads/writes) that the forwarding path cannot yet supply.
- Holds decode/issue (stall_o) until each source operand is either retired or being written back that cycle.
- Sits between decode and EX.
- Provides a consecutive-stall watchdog and a stall performance counter.

Parameters:
- NUM_REGS, 32, number of GPRs tracked; x0 is never tracked.
- CNT_W, 2, width of the per-register pending counter; maximum outstanding writes per register is 2^CNT_W-1.
- STALL_TIMEOUT, 1024, number of consecutive stall cycles that sets timeout_o.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1 / dec_rs2  in  5  source register indices
- dec_uses_rs1 / dec_uses_rs2  in  1  the source is actually read
- dec_csr  in  12  CSR address read/written by the instruction
- dec_uses_csr  in  1  the instruction reads the CSR
- dec_rd  in  5  destination register
- dec_long  in  1  rd is produced by a long-latency unit (load)
- dec_csr_we  in  1  the instruction writes dec_csr
- wb_valid  in  1  long-latency GPR result written back this cycle
- wb_rd  in  5  register written back
- csr_wb_valid  in  1  pending CSR write retired this cycle
- kill_valid  in  1  a squashed long-latency op releases its entry
- kill_rd  in  5  register of the squashed op
- kill_csr  in  1  a squashed CSR write releases the CSR entry
- stall_o  out  1  hold decode; the instruction is not issued
- issue_o  out  1  dec_valid && !stall_o
- busy_o  out  1  any counter non-zero, or the CSR entry is pending
- stall_cnt_o  out  32  total stall cycles, wraps modulo 2^32
- timeout_o  out  1  sticky watchdog flag
- err_underflow_o  out  1  sticky; a release arrived for a counter already at 0

Behaviour:
- Reset (async, rst_n=0): all counters=0, csr_pend=0, csr_addr=0, stall_cnt_o=0, consecutive counter=0, timeout_o=0, err_underflow_o=0.
  - Consequently stall_o=0, issue_o=dec_valid, busy_o=0.
  - Reset mid-operation discards every pending entry.
- pend(r) is defined as cnt[r] minus the number of releases to r this cycle, greater than 0. Releases are (wb_valid && wb_rd==r) plus (kill_valid && kill_rd==r). This is a same-cycle WB bypass: the forwarding mux supplies WB data.
- r==0 is never pending, never incremented, and releases to it are ignored.
- stall_o is combinational and is high when dec_valid and any of the following holds:
  - dec_uses_rs1 && pend(dec_rs1)
  - dec_uses_rs2 && pend(dec_rs2)
  - dec_uses_csr && csr_pend && csr_addr==dec_csr && !(csr_wb_valid||kill_csr)
  - dec_csr_we && csr_pend && !(csr_wb_valid||kill_csr), so only one CSR write is ever outstanding
  - dec_long && dec_rd!=0 && cnt[dec_rd]==max, so a counter never saturates
- Counter update (rising edge): cnt[r] <= cnt[r] + inc - releases.
  - inc = issue_o && dec_long && dec_rd==r.
  - Simultaneous inc and release on the same r gives a net change of 0.
  - wb and kill to the same r in one cycle subtract 2.
  - A release on cnt==0 leaves it at 0 and sets err_underflow_o.
- CSR entry: issue_o && dec_csr_we sets csr_pend=1 and latches csr_addr.
  - csr_wb_valid or kill_csr clears it.
  - Set and clear in the same cycle: the set wins, for the new instruction.
  - A clear while not pending sets err_underflow_o.
- Watchdog and perf counter:
  - stall_cnt_o increments every cycle stall_o=1.
  - The consecutive counter increments while stall_o=1 and resets to 0 when stall_o=0.
  - When the consecutive counter reaches STALL_TIMEOUT, timeout_o sets and stays high until reset.
- Latency: an issue in cycle N is visible to decode in cycle N+1. A release in cycle N clears the stall in cycle N (bypass).

Decomposition:
- Shared package hazard_pkg holds:
  - REG_IDX_W=5, CSR_ADDR_W=12.
  - Function is_x0.
  - Stall-cause enum (NONE, RS1, RS2, CSR_RD, CSR_WR, SAT), exported for debug and used by the bench.
- One sub-module, pend_counter: a single CNT_W up/down counter with inc, dec[1:0], saturation flag and underflow flag. It is instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
- Issue load rd=5 in cycle 0; next cycle decode rs1=5 -> stall_o=1 until wb_valid,wb_rd=5. In that wb cycle stall_o=0 and issue_o=1; cnt[5]=0 afterwards.
- Issue load rd=0, then decode rs2=0 -> never stalls; busy_o stays 0.
- Issue 3 loads to rd=7 (CNT_W=2), then a 4th load to rd=7 -> stall_o=1 (SAT). One wb to rd=7 in the same cycle -> the 4th issues and cnt stays 3.
- CSR write to 0x300 is pending. A CSR read of 0x305 issues; a read of 0x300 stalls. kill_csr clears it -> the read issues and err_underflow_o stays 0.
- wb_valid to rd=9 with cnt[9]=0 -> err_underflow_o=1, sticky across later traffic. Assert rst_n=0 mid-stall -> stall_o=0 and all flags clear immediately, asynchronously.
- Hold a dependent instruction with no wb for STALL_TIMEOUT=16 cycles -> timeout_o rises after the 16th stall cycle and stall_cnt_o=16.
